// File: rtl/fifo_rd_skid_buf.sv
// Two-entry, order-preserving output buffer for the FIFO read adapter.
// The head entry is always the oldest word and feeds the stream data directly.
module fifo_rd_skid_buf #(
   parameter int data_width = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push,
   input  logic [data_width-1:0] i_pushData,
   input  logic                  i_pop,
   output logic [1:0]            o_occ,
   output logic [data_width-1:0] o_headData
);

   logic [data_width-1:0] r_head;
   logic [data_width-1:0] r_tail;
   logic [1:0]            r_occ;
   logic                  w_popOk;
   logic                  w_pushOk;

   // A pop of an empty buffer or a push into a full one without a pop is ignored.
   assign w_popOk  = i_pop & (r_occ != 2'd0);
   assign w_pushOk = i_push & ((r_occ != 2'd2) | w_popOk);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= 2'd0;
      end else begin
         case ({w_pushOk, w_popOk})
            2'b10: begin
               if (r_occ == 2'd0) begin
                  r_head <= i_pushData;
               end else begin
                  r_tail <= i_pushData;
               end
               r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               r_head <= r_tail;
               r_occ  <= r_occ - 2'd1;
            end
            2'b11: begin
               // Simultaneous push and pop: occupancy holds and the head advances.
               if (r_occ == 2'd2) begin
                  r_head <= r_tail;
                  r_tail <= i_pushData;
               end else begin
                  r_head <= i_pushData;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_occ      = r_occ;
   assign o_headData = r_head;

endmodule

// File: rtl/fifo_rd_to_axis.sv
// Drains a synchronous FIFO read port (FWFT or one-cycle latency) into an
// AXI-Stream master, framing packets of pkt_len beats with m_axis_last.
module fifo_rd_to_axis #(
   parameter int fifo_read_latency = 1,
   parameter int data_width        = 32,
   parameter int pkt_len           = 16,
   parameter int simulation_delay  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   output logic                    fifo_ren,
   input  logic [data_width-1:0]   fifo_dout,
   input  logic                    fifo_empty_n,
   output logic [data_width-1:0]   m_axis_data,
   output logic                    m_axis_valid,
   input  logic                    m_axis_ready,
   output logic                    m_axis_last,
   output logic [$clog2(pkt_len):0] beat_cnt
);

   function automatic int clogb2(input int value);
      int v;
      int bits;
      v    = value;
      bits = 0;
      while (v > 0) begin
         v    = v >> 1;
         bits = bits + 1;
      end
      return bits;
   endfunction

   localparam int                  CntWidth = clogb2(pkt_len - 1) + 1;
   localparam logic [CntWidth-1:0] LastBeat = CntWidth'(pkt_len - 1);

   logic [1:0]            w_occ;
   logic [data_width-1:0] w_head;
   logic                  w_valid;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_inflight;
   logic [2:0]            w_credit;
   logic [CntWidth-1:0]   r_beatCnt;

   if (fifo_read_latency < 0 || fifo_read_latency > 1 || pkt_len < 1 || pkt_len > 256
       || simulation_delay < 0) begin : g_badParams
      $error("fifo_rd_to_axis: illegal parameter value");
   end

   assign w_valid = (w_occ != 2'd0);
   assign w_pop   = w_valid & m_axis_ready;

   // Occupancy after this cycle's pop, counting the pending read, must leave room.
   assign w_credit = {1'b0, w_occ} + {2'b00, w_inflight} - {2'b00, w_pop};
   assign fifo_ren = rst_n & fifo_empty_n & (w_credit < 3'd2);

   if (fifo_read_latency == 0) begin : g_fwft
      assign w_inflight = 1'b0;
      assign w_push     = fifo_ren;
   end else begin : g_std
      logic r_inflight;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_inflight <= 1'b0;
         end else begin
            r_inflight <= fifo_ren;
         end
      end

      assign w_inflight = r_inflight;
      assign w_push     = r_inflight;
   end

   fifo_rd_skid_buf #(
      .data_width (data_width)
   ) u_skidBuf (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (w_push),
      .i_pushData (fifo_dout),
      .i_pop      (w_pop),
      .o_occ      (w_occ),
      .o_headData (w_head)
   );

   // Beat index only moves on accepted beats, so a dry FIFO holds the framing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beatCnt <= '0;
      end else if (w_pop) begin
         if (r_beatCnt == LastBeat) begin
            r_beatCnt <= '0;
         end else begin
            r_beatCnt <= r_beatCnt + 1'b1;
         end
      end
   end

   assign m_axis_valid = w_valid;
   assign m_axis_data  = w_head;
   assign m_axis_last  = w_valid & (r_beatCnt == LastBeat);
   assign beat_cnt     = r_beatCnt;

endmodule

// File: tb/tb_fifo_rd_to_axis.sv
// Directed bench for fifo_rd_to_axis: three instances (latency 1 / latency 0 with
// 4-beat packets, latency 1 with 1-beat packets), each fed by a small FIFO model.
module tb_fifo_rd_to_axis;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   int testCount = 0;
   int failCount = 0;

   // Instance A: standard FIFO, pkt_len 4
   logic [31:0] memA [0:63];
   int          wrA = 0;
   int          rdA = 0;
   logic [31:0] doutA = '0;
   logic        emptyNA;
   logic        readyA = 1'b0;
   logic        renA, validA, lastA;
   logic [31:0] dataA;
   logic [2:0]  cntA;

   // Instance B: FWFT FIFO, pkt_len 4
   logic [31:0] memB [0:63];
   int          wrB = 0;
   int          rdB = 0;
   logic [31:0] doutB;
   logic        emptyNB;
   logic        readyB = 1'b0;
   logic        renB, validB, lastB;
   logic [31:0] dataB;
   logic [2:0]  cntB;

   // Instance C: standard FIFO, pkt_len 1
   logic [31:0] memC [0:63];
   int          wrC = 0;
   int          rdC = 0;
   logic [31:0] doutC = '0;
   logic        emptyNC;
   logic        readyC = 1'b0;
   logic        renC, validC, lastC;
   logic [31:0] dataC;
   logic [0:0]  cntC;

   assign emptyNA = (wrA != rdA);
   assign emptyNB = (wrB != rdB);
   assign emptyNC = (wrC != rdC);
   assign doutB   = memB[rdB];

   always @(posedge clk) begin
      if (renA) begin
         doutA <= memA[rdA];
         rdA   <= rdA + 1;
      end
   end

   always @(posedge clk) begin
      if (renB) begin
         rdB <= rdB + 1;
      end
   end

   always @(posedge clk) begin
      if (renC) begin
         doutC <= memC[rdC];
         rdC   <= rdC + 1;
      end
   end

   fifo_rd_to_axis #(
      .fifo_read_latency (1), .data_width (32), .pkt_len (4), .simulation_delay (1)
   ) u_dutA (
      .clk (clk), .rst_n (rst_n), .fifo_ren (renA), .fifo_dout (doutA),
      .fifo_empty_n (emptyNA), .m_axis_data (dataA), .m_axis_valid (validA),
      .m_axis_ready (readyA), .m_axis_last (lastA), .beat_cnt (cntA)
   );

   fifo_rd_to_axis #(
      .fifo_read_latency (0), .data_width (32), .pkt_len (4), .simulation_delay (1)
   ) u_dutB (
      .clk (clk), .rst_n (rst_n), .fifo_ren (renB), .fifo_dout (doutB),
      .fifo_empty_n (emptyNB), .m_axis_data (dataB), .m_axis_valid (validB),
      .m_axis_ready (readyB), .m_axis_last (lastB), .beat_cnt (cntB)
   );

   fifo_rd_to_axis #(
      .fifo_read_latency (1), .data_width (32), .pkt_len (1), .simulation_delay (1)
   ) u_dutC (
      .clk (clk), .rst_n (rst_n), .fifo_ren (renC), .fifo_dout (doutC),
      .fifo_empty_n (emptyNC), .m_axis_data (dataC), .m_axis_valid (validC),
      .m_axis_ready (readyC), .m_axis_last (lastC), .beat_cnt (cntC)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkDut(input int which, input string tag, input logic expValid,
                           input logic [31:0] expData, input logic expLast, input int expCnt);
      logic        obsValid;
      logic        obsLast;
      logic [31:0] obsData;
      logic [31:0] obsCnt;
      case (which)
         0: begin obsValid = validA; obsLast = lastA; obsData = dataA; obsCnt = 32'(cntA); end
         1: begin obsValid = validB; obsLast = lastB; obsData = dataB; obsCnt = 32'(cntB); end
         default: begin
            obsValid = validC; obsLast = lastC; obsData = dataC; obsCnt = 32'(cntC);
         end
      endcase
      checkOutput({tag, ".valid"}, {31'd0, obsValid}, {31'd0, expValid});
      if (expValid) checkOutput({tag, ".data"}, obsData, expData);
      checkOutput({tag, ".last"}, {31'd0, obsLast}, {31'd0, expLast});
      checkOutput({tag, ".cnt"}, obsCnt, 32'(expCnt));
   endtask

   task automatic applyStimulus(input int which, input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         case (which)
            0: begin memA[wrA] = base + 32'(i); wrA++; end
            1: begin memB[wrB] = base + 32'(i); wrB++; end
            default: begin memC[wrC] = base + 32'(i); wrC++; end
         endcase
      end
   endtask

   // Read enable must never reach a FIFO that reports empty.
   always begin
      @(negedge clk);
      #2;
      checkOutput("renWhileEmptyA", {31'd0, renA & ~emptyNA}, 32'd0);
      checkOutput("renWhileEmptyB", {31'd0, renB & ~emptyNB}, 32'd0);
      checkOutput("renWhileEmptyC", {31'd0, renC & ~emptyNC}, 32'd0);
   end

   initial begin
      rst_n  = 1'b0;
      readyA = 1'b1;
      readyB = 1'b1;
      readyC = 1'b1;
      applyStimulus(0, 32'h0, 8);
      repeat (3) @(negedge clk);
      #1;
      checkDut(0, "resetA", 1'b0, 32'd0, 1'b0, 0);
      checkDut(1, "resetB", 1'b0, 32'd0, 1'b0, 0);
      checkDut(2, "resetC", 1'b0, 32'd0, 1'b0, 0);
      checkOutput("reset.dataA", dataA, 32'd0);
      checkOutput("reset.dataB", dataB, 32'd0);
      checkOutput("reset.renA", {31'd0, renA}, 32'd0);

      // Latency 1, pkt_len 4, preloaded 0..7
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("lat1.renFirst", {31'd0, renA}, 32'd1);
      checkDut(0, "lat1.t0", 1'b0, 32'd0, 1'b0, 0);
      @(negedge clk); #1;
      checkDut(0, "lat1.t1", 1'b0, 32'd0, 1'b0, 0);
      checkOutput("lat1.renSecond", {31'd0, renA}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         checkDut(0, $sformatf("lat1.beat%0d", i), 1'b1, 32'(i), (i % 4) == 3, i % 4);
      end
      @(negedge clk); #1;
      checkDut(0, "lat1.drained", 1'b0, 32'd0, 1'b0, 0);

      // Latency 0, same pattern offset by 0x10
      @(negedge clk);
      applyStimulus(1, 32'h10, 8);
      #1;
      checkOutput("lat0.renFirst", {31'd0, renB}, 32'd1);
      checkDut(1, "lat0.t0", 1'b0, 32'd0, 1'b0, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         checkDut(1, $sformatf("lat0.beat%0d", i), 1'b1, 32'h10 + 32'(i), (i % 4) == 3, i % 4);
      end
      @(negedge clk); #1;
      checkDut(1, "lat0.drained", 1'b0, 32'd0, 1'b0, 0);

      // Backpressure on latency 1
      @(negedge clk);
      applyStimulus(0, 32'h20, 8);
      @(negedge clk); #1;
      checkDut(0, "bp.wait", 1'b0, 32'd0, 1'b0, 0);
      @(negedge clk); #1;
      checkDut(0, "bp.beat0", 1'b1, 32'h20, 1'b0, 0);
      @(negedge clk); #1;
      checkDut(0, "bp.beat1", 1'b1, 32'h21, 1'b0, 1);
      readyA = 1'b0;
      #1;
      checkOutput("bp.renStop", {31'd0, renA}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         checkDut(0, $sformatf("bp.hold%0d", k), 1'b1, 32'h21, 1'b0, 1);
         checkOutput($sformatf("bp.holdRen%0d", k), {31'd0, renA}, 32'd0);
      end
      readyA = 1'b1;
      #1;
      checkOutput("bp.renResume", {31'd0, renA}, 32'd1);
      for (int i = 2; i < 8; i++) begin
         @(negedge clk); #1;
         checkDut(0, $sformatf("bp.beat%0d", i), 1'b1, 32'h20 + 32'(i), (i % 4) == 3, i % 4);
      end
      @(negedge clk); #1;
      checkDut(0, "bp.drained", 1'b0, 32'd0, 1'b0, 0);

      // FIFO runs dry mid-packet
      @(negedge clk);
      applyStimulus(0, 32'h40, 2);
      @(negedge clk); #1;
      checkDut(0, "dry.wait", 1'b0, 32'd0, 1'b0, 0);
      @(negedge clk); #1;
      checkDut(0, "dry.beat0", 1'b1, 32'h40, 1'b0, 0);
      @(negedge clk); #1;
      checkDut(0, "dry.beat1", 1'b1, 32'h41, 1'b0, 1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); #1;
         checkDut(0, $sformatf("dry.idle%0d", k), 1'b0, 32'd0, 1'b0, 2);
      end
      applyStimulus(0, 32'h42, 2);
      @(negedge clk); #1;
      checkDut(0, "dry.refillWait", 1'b0, 32'd0, 1'b0, 2);
      @(negedge clk); #1;
      checkDut(0, "dry.beat2", 1'b1, 32'h42, 1'b0, 2);
      @(negedge clk); #1;
      checkDut(0, "dry.beat3", 1'b1, 32'h43, 1'b1, 3);
      @(negedge clk); #1;
      checkDut(0, "dry.drained", 1'b0, 32'd0, 1'b0, 0);

      // pkt_len 1: every beat is last
      @(negedge clk);
      applyStimulus(2, 32'h50, 3);
      @(negedge clk); #1;
      checkDut(2, "pkt1.wait", 1'b0, 32'd0, 1'b0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         checkDut(2, $sformatf("pkt1.beat%0d", i), 1'b1, 32'h50 + 32'(i), 1'b1, 0);
      end
      @(negedge clk); #1;
      checkDut(2, "pkt1.drained", 1'b0, 32'd0, 1'b0, 0);

      // Reset with a buffered word and a read in flight
      @(negedge clk);
      applyStimulus(0, 32'h60, 5);
      @(negedge clk); #1;
      checkDut(0, "rst.wait", 1'b0, 32'd0, 1'b0, 0);
      @(negedge clk); #1;
      checkDut(0, "rst.beat0", 1'b1, 32'h60, 1'b0, 0);
      @(negedge clk); #1;
      checkDut(0, "rst.beat1", 1'b1, 32'h61, 1'b0, 1);
      @(negedge clk); #1;
      checkDut(0, "rst.beat2", 1'b1, 32'h62, 1'b0, 2);
      readyA = 1'b0;
      rst_n  = 1'b0;
      #1;
      checkDut(0, "rst.asserted", 1'b0, 32'd0, 1'b0, 0);
      checkOutput("rst.data", dataA, 32'd0);
      checkOutput("rst.ren", {31'd0, renA}, 32'd0);
      @(negedge clk); #1;
      checkOutput("rst.renHeld", {31'd0, renA}, 32'd0);
      @(negedge clk);
      readyA = 1'b1;
      rst_n  = 1'b1;
      #1;
      checkOutput("rst.renRelease", {31'd0, renA}, 32'd1);
      @(negedge clk); #1;
      checkDut(0, "rst.postWait", 1'b0, 32'd0, 1'b0, 0);
      @(negedge clk); #1;
      checkDut(0, "rst.postBeat0", 1'b1, 32'h64, 1'b0, 0);
      @(negedge clk); #1;
      checkDut(0, "rst.postDrained", 1'b0, 32'd0, 1'b0, 1);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
